// File: rtl/isp_mosaic.sv
// Re-mosaics an RGB pixel stream into a single-channel Bayer raw stream (inverse of isp_demosaic).
// Optional frame geometry checker enabled by defining MOSAIC_GEOM_CHK_EN.
module isp_mosaic #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080,
  parameter int unsigned BAYER  = 0
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_r,
  input  logic [BITS-1:0] in_g,
  input  logic [BITS-1:0] in_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic            out_frame_err
);

  localparam int unsigned XW  = $clog2(WIDTH + 1);
  localparam int unsigned YW  = $clog2(HEIGHT + 1);
  localparam logic [1:0]  CFA = 2'(BAYER);

  logic            href_q, vsync_q, sync_ok_q, sync_ok_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            href_fall, vsync_rise;
  logic            sx, sy;
  logic [BITS-1:0] sel, raw_d;

  // Position tracking and CFA colour selection, using pre-increment counters
  always_comb begin
    href_fall  = href_q & ~in_href;
    vsync_rise = in_vsync & ~vsync_q;
    sync_ok_d  = sync_ok_q | vsync_rise;
    x_d        = in_href ? x_q + XW'(1) : '0;
    y_d        = y_q;
    if (in_vsync)       y_d = '0;
    else if (href_fall) y_d = y_q + YW'(1);
    sx = x_q[0] ^ CFA[0];
    sy = y_q[0] ^ CFA[1];
    case ({sy, sx})
      2'b00:   sel = in_r;
      2'b11:   sel = in_b;
      default: sel = in_g;
    endcase
    raw_d = (in_href & sync_ok_d) ? sel : '0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      href_q    <= 1'b0;
      vsync_q   <= 1'b0;
      sync_ok_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_raw   <= '0;
    end else begin
      href_q    <= in_href;
      vsync_q   <= in_vsync;
      sync_ok_q <= sync_ok_d;
      x_q       <= x_d;
      y_q       <= y_d;
      out_href  <= in_href & sync_ok_d;
      out_vsync <= in_vsync;
      out_raw   <= raw_d;
    end
  end

`ifdef MOSAIC_GEOM_CHK_EN
  logic len_err_q, len_err_d, frame_err_q, frame_err_d;

  // Flag short/long lines; report at the next frame start unless unsynced or empty
  always_comb begin
    len_err_d   = len_err_q;
    frame_err_d = 1'b0;
    if (href_fall && (x_q != XW'(WIDTH))) len_err_d = 1'b1;
    if (vsync_rise) begin
      frame_err_d = sync_ok_q && (y_q != '0) && (len_err_q || (y_q != YW'(HEIGHT)));
      len_err_d   = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      len_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      len_err_q   <= len_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_frame_err = frame_err_q;
`else
  assign out_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_isp_mosaic.sv
// Scoreboard bench for isp_mosaic: four instances (BAYER 0..3) driven by one shared stream.
module tb_isp_mosaic;

`ifdef MOSAIC_GEOM_CHK_EN
  localparam bit GEOM = 1'b1;
`else
  localparam bit GEOM = 1'b0;
`endif

  typedef struct packed {
    logic            href;
    logic            vsync;
    logic [3:0][7:0] raw;
    logic            ferr;
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst;
  logic       in_href, in_vsync;
  logic [7:0] in_r, in_g, in_b;
  logic       o_href [4];
  logic       o_vsync [4];
  logic [7:0] o_raw [4];
  logic       o_ferr [4];

  int   checks = 0;
  int   failures = 0;
  bit   synced, vs_prev, pend, ferr_next;
  exp_t sb[$];

  always #5 pclk = ~pclk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    isp_mosaic #(.BITS(8), .WIDTH(8), .HEIGHT(4), .BAYER(k)) u_dut (
      .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .out_href(o_href[k]), .out_vsync(o_vsync[k]), .out_raw(o_raw[k]),
      .out_frame_err(o_ferr[k])
    );
  end

  function automatic logic [7:0] pick(input int bay, input int row, input int col);
    int sx, sy;
    sx = (col % 2) ^ (bay % 2);
    sy = (row % 2) ^ (bay / 2);
    if (sx == 0 && sy == 0) return in_r;
    if (sx == 1 && sy == 1) return in_b;
    return in_g;
  endfunction

  // One pclk of stimulus; expectation queued now, compared after the capturing edge
  task automatic cyc(input logic h, input logic v, input int row, input int col, input bit loose);
    exp_t e, g;
    in_href  = h;
    in_vsync = v;
    if (rst) begin
      synced  = 1'b0;
      vs_prev = 1'b0;
    end else begin
      if (v && !vs_prev) synced = 1'b1;
      vs_prev = v;
    end
    e.href  = h & synced & ~rst;
    e.vsync = v & ~rst;
    e.ferr  = ferr_next & ~rst;
    for (int k = 0; k < 4; k++) e.raw[k] = e.href ? pick(k, row, col) : 8'h00;
    sb.push_back(e);
    @(posedge pclk);
    #1;
    g = sb.pop_front();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_href[k] !== g.href) begin
        failures++;
        $display("FAIL href dut%0d r%0d c%0d got %b exp %b", k, row, col, o_href[k], g.href);
      end
      checks++;
      if (o_vsync[k] !== g.vsync) begin
        failures++;
        $display("FAIL vsync dut%0d got %b exp %b", k, o_vsync[k], g.vsync);
      end
      if (!loose || !h) begin
        checks++;
        if (o_raw[k] !== g.raw[k]) begin
          failures++;
          $display("FAIL raw dut%0d r%0d c%0d got %h exp %h", k, row, col, o_raw[k], g.raw[k]);
        end
      end
      if (!loose) begin
        checks++;
        if (o_ferr[k] !== g.ferr) begin
          failures++;
          $display("FAIL frame_err dut%0d got %b exp %b", k, o_ferr[k], g.ferr);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_href = 1'b0; in_vsync = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    synced = 1'b0; vs_prev = 1'b0; pend = 1'b0; ferr_next = 1'b0;
    sb.delete();
  endtask

  // Vsync pulse, nl lines with one blanking cycle between them, trailing blanking
  task automatic frame(input int nl, input int len, input int short_line, input int short_len);
    bit bad;
    int n;
    bad = (nl != 4);
    ferr_next = pend;
    cyc(1'b0, 1'b1, 0, 0, 1'b0);
    ferr_next = 1'b0;
    cyc(1'b0, 1'b1, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    for (int l = 0; l < nl; l++) begin
      n = (l == short_line) ? short_len : len;
      if (n != 8) bad = 1'b1;
      for (int c = 0; c < n; c++) cyc(1'b1, 1'b0, l, c, 1'b0);
      cyc(1'b0, 1'b0, l, 0, 1'b0);
    end
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    pend = GEOM && (nl != 0) && bad;
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_href[k] !== 1'b0 || o_vsync[k] !== 1'b0 || o_raw[k] !== 8'h00 || o_ferr[k] !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d got href=%b vsync=%b raw=%h ferr=%b exp all 0",
                 name, k, o_href[k], o_vsync[k], o_raw[k], o_ferr[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_href = 1'b1; in_vsync = 1'b1;
    in_r = 8'h11; in_g = 8'h22; in_b = 8'h33;
    repeat (3) @(posedge pclk);
    #1;
    check_zero("reset_state");
    in_href = 1'b0; in_vsync = 1'b0;
    rst = 1'b0;
    synced = 1'b0; vs_prev = 1'b0; pend = 1'b0; ferr_next = 1'b0;
  endtask

  task automatic test_presync();
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 8; c++) cyc(1'b1, 1'b0, l, c, 1'b0);
      cyc(1'b0, 1'b0, 0, 0, 1'b0);
    end
    frame(4, 8, -1, 0);
    frame(4, 8, -1, 0);
  endtask

  task automatic test_bayer_frames();
    in_r = 8'h11; in_g = 8'h22; in_b = 8'h33;
    frame(4, 8, -1, 0);
    frame(4, 8, -1, 0);
  endtask

  task automatic test_geometry();
    frame(4, 8, 1, 7);
    frame(4, 8, -1, 0);
    frame(3, 8, -1, 0);
    frame(4, 8, -1, 0);
    frame(0, 8, -1, 0);
    frame(4, 8, -1, 0);
    frame(4, 8, -1, 0);
  endtask

  task automatic test_pulse_lines();
    frame(4, 1, -1, 0);
    frame(4, 8, -1, 0);
  endtask

  task automatic test_colors();
    for (int f = 0; f < 3; f++) begin
      in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
      frame(4, 8, -1, 0);
    end
    in_r = 8'hFF; in_g = 8'h00; in_b = 8'hA5;
    frame(4, 8, -1, 0);
  endtask

  task automatic test_random_timing();
    for (int i = 0; i < 120; i++)
      cyc(1'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0), 0, 0, 1'b1);
  endtask

  task automatic test_reset_midline();
    do_reset();
    in_r = 8'h11; in_g = 8'h22; in_b = 8'h33;
    frame(4, 8, -1, 0);
    ferr_next = pend;
    cyc(1'b0, 1'b1, 0, 0, 1'b0);
    ferr_next = 1'b0;
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 5; c++) cyc(1'b1, 1'b0, 0, c, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    for (int c = 5; c < 8; c++) cyc(1'b1, 1'b0, 0, c, 1'b0);
    rst = 1'b0;
    pend = 1'b0;
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 0, c, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    frame(4, 8, -1, 0);
    frame(4, 8, -1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_presync();
    test_bayer_frames();
    test_geometry();
    test_pulse_lines();
    test_colors();
    test_random_timing();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
